// File: rtl/trace_stream_serializer.sv
// Trace stream serializer: splits IN_WIDTH-bit trace packets into 32-bit words,
// least-significant word first, and opens every frame with a {HDR_MAGIC, frame_seq} header.
module trace_stream_serializer #(
    parameter int          IN_WIDTH  = 96,
    parameter logic [15:0] HDR_MAGIC = 16'hA5C3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [IN_WIDTH-1:0] s_axis_tdata,
    input  logic                s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tlast,
    output logic [15:0]         frame_seq,
    output logic [31:0]         packets_accepted,
    output logic                busy
);
    localparam int BEATS = IN_WIDTH / 32;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                 state, state_n;
    logic [BW-1:0]          beat, beat_n;
    logic [BEATS-1:0][31:0] packet, packet_n;
    logic                   held_last, held_last_n;
    logic                   new_frame, new_frame_n;
    logic [15:0]            seq_n;
    logic [31:0]            tdata_n;
    logic                   tlast_n;
    logic                   last_beat;
    logic                   in_hs;

    assign last_beat     = (beat == LAST_BEAT);
    assign s_axis_tready = (state == IDLE) || (state == DATA && last_beat && m_axis_tready);
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = (state != IDLE);
    assign busy          = (state != IDLE);

    // Next-state logic; the output word is computed from the next state so it can be registered.
    always_comb begin
        state_n     = state;
        beat_n      = beat;
        packet_n    = packet;
        held_last_n = held_last;
        new_frame_n = new_frame;
        seq_n       = frame_seq;
        case (state)
            IDLE: begin
                if (s_axis_tvalid) begin
                    packet_n    = s_axis_tdata;
                    held_last_n = s_axis_tlast;
                    new_frame_n = 1'b0;
                    beat_n      = '0;
                    state_n     = new_frame ? HEADER : DATA;
                end
            end
            HEADER: begin
                if (m_axis_tready) begin
                    beat_n  = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (m_axis_tready) begin
                    if (!last_beat) begin
                        beat_n = beat + 1'b1;
                    end else begin
                        beat_n = '0;
                        if (held_last) begin
                            seq_n       = frame_seq + 16'd1;
                            new_frame_n = 1'b1;
                        end
                        // Zero-bubble capture: the next packet is taken on the last-beat handshake.
                        if (s_axis_tvalid) begin
                            packet_n    = s_axis_tdata;
                            held_last_n = s_axis_tlast;
                            new_frame_n = 1'b0;
                            state_n     = held_last ? HEADER : DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        tdata_n = 32'h0;
        tlast_n = 1'b0;
        if (state_n == HEADER) begin
            tdata_n = {HDR_MAGIC, seq_n};
        end else if (state_n == DATA) begin
            tdata_n = packet_n[beat_n];
            tlast_n = (beat_n == LAST_BEAT) && held_last_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            beat             <= '0;
            packet           <= '0;
            held_last        <= 1'b0;
            new_frame        <= 1'b1;
            frame_seq        <= 16'h0;
            packets_accepted <= 32'h0;
            m_axis_tdata     <= 32'h0;
            m_axis_tlast     <= 1'b0;
        end else begin
            state            <= state_n;
            beat             <= beat_n;
            packet           <= packet_n;
            held_last        <= held_last_n;
            new_frame        <= new_frame_n;
            frame_seq        <= seq_n;
            packets_accepted <= packets_accepted + {31'd0, in_hs};
            m_axis_tdata     <= tdata_n;
            m_axis_tlast     <= tlast_n;
        end
    end

endmodule
